// File: rtl/picosoc_pkg.sv
// Shared definitions for the dual-port PicoSoC memory: FSM encoding and read latency.
package picosoc_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } mem_state_e;

    localparam int RD_LAT_BASE = 1;

    function automatic int rd_lat(input bit out_reg);
        return RD_LAT_BASE + int'(out_reg);
    endfunction

endpackage

// File: rtl/picosoc_mem_dp_ram.sv
// Byte-enable memory array: one write port, two registered read ports, read-first.
module picosoc_mem_dp_ram #(
    parameter int WORDS  = 256,
    parameter int DATA_W = 32,
    parameter int IW     = $clog2(WORDS),
    parameter int NB     = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IW-1:0]     waddr_i,
    input  logic [NB-1:0]     wbe_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_a_i,
    input  logic [IW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic              re_b_i,
    input  logic [IW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;

    // Reads sample the array before this edge's write lands, giving read-first.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
        if (re_a_i) rdata_a_q <= mem_q[raddr_a_i];
        if (re_b_i) rdata_b_q <= mem_q[raddr_b_i];
    end

    assign rdata_a_o = rdata_a_q;
    assign rdata_b_o = rdata_b_q;

endmodule

// File: rtl/picosoc_mem_dp.sv
// Dual-port memory: port A read/write, port B read-only, with a zero-fill sweep after reset.
module picosoc_mem_dp
    import picosoc_pkg::*;
#(
    parameter int WORDS          = 256,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 22,
    parameter bit OUT_REG        = 1'b0,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [DATA_W/8-1:0]   a_wen,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_W-1:0]     a_rdata,
    output logic                  a_err,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_W-1:0]     b_addr,
    output logic                  b_rvalid,
    output logic [DATA_W-1:0]     b_rdata,
    output logic                  b_err
);

    localparam int NB  = DATA_W / 8;
    localparam int IW  = $clog2(WORDS);
    localparam int LAT = rd_lat(OUT_REG);
    localparam logic [ADDR_W:0] WORDS_X = (ADDR_W+1)'(WORDS);
    localparam logic [IW-1:0]   LAST    = IW'(WORDS - 1);

    mem_state_e  state_q, state_d;
    logic [IW-1:0] ctr_q, ctr_d;
    logic        rdy_q;

    logic        acc_a, acc_b, inr_a, inr_b;
    logic        ram_we;
    logic [IW-1:0] ram_waddr;
    logic [NB-1:0] ram_wbe;
    logic [DATA_W-1:0] ram_wdata;
    logic [1:0][DATA_W-1:0] ram_rd, val1, hold_q, rd_out;
    logic [1:0]  acc, inr;
    logic [LAT:1][1:0] vld_pipe_q, err_pipe_q;

    // Full-width compare so out-of-range addresses never alias onto real words.
    assign inr_a = ({1'b0, a_addr} < WORDS_X);
    assign inr_b = ({1'b0, b_addr} < WORDS_X);
    assign acc_a = a_valid && rdy_q && !rst;
    assign acc_b = b_valid && rdy_q && !rst;
    assign acc   = {acc_b, acc_a};
    assign inr   = {inr_b, inr_a};

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        case (state_q)
            ST_CLEAR: begin
                ctr_d = ctr_q + IW'(1);
                if (ctr_q == LAST) begin
                    state_d = ST_RUN;
                    ctr_d   = '0;
                end
            end
            ST_RUN:  ;
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            ctr_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            rdy_q   <= (state_d == ST_RUN);
        end
    end

    // The sweep owns the write port while clearing; port A owns it otherwise.
    always_comb begin
        ram_we    = acc_a && inr_a && (|a_wen);
        ram_waddr = a_addr[IW-1:0];
        ram_wbe   = a_wen;
        ram_wdata = a_wdata;
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = ctr_q;
            ram_wbe   = '1;
            ram_wdata = '0;
        end
    end

    picosoc_mem_dp_ram #(
        .WORDS  (WORDS),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i     (clk),
        .we_i      (ram_we),
        .waddr_i   (ram_waddr),
        .wbe_i     (ram_wbe),
        .wdata_i   (ram_wdata),
        .re_a_i    (acc_a && inr_a),
        .raddr_a_i (a_addr[IW-1:0]),
        .rdata_a_o (ram_rd[0]),
        .re_b_i    (acc_b && inr_b),
        .raddr_b_i (b_addr[IW-1:0]),
        .rdata_b_o (ram_rd[1])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
            err_pipe_q <= '0;
            hold_q     <= '0;
        end else begin
            vld_pipe_q[1] <= acc;
            err_pipe_q[1] <= acc & ~inr;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe_q[s] <= vld_pipe_q[s-1];
                err_pipe_q[s] <= err_pipe_q[s-1];
            end
            for (int p = 0; p < 2; p++) begin
                if (vld_pipe_q[1][p]) hold_q[p] <= val1[p];
            end
        end
    end

    // With OUT_REG the hold register doubles as the output stage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            val1[p]   = err_pipe_q[1][p] ? '0 : ram_rd[p];
            rd_out[p] = (!OUT_REG && vld_pipe_q[1][p]) ? val1[p] : hold_q[p];
        end
    end

    assign a_ready  = rdy_q;
    assign b_ready  = rdy_q;
    assign a_rvalid = vld_pipe_q[LAT][0];
    assign b_rvalid = vld_pipe_q[LAT][1];
    assign a_err    = vld_pipe_q[LAT][0] & err_pipe_q[LAT][0];
    assign b_err    = vld_pipe_q[LAT][1] & err_pipe_q[LAT][1];
    assign a_rdata  = rd_out[0];
    assign b_rdata  = rd_out[1];

endmodule
